// File: rtl/mips_pkg.sv
// Shared definitions for the pipe_MIPS32 program loader: loader states, the HLT opcode
// and the default instruction/data memory word-address width.
package mips_pkg;

    localparam int         MEM_ADDR_W = 10;
    localparam logic [5:0] HLT_OP     = 6'h3f;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } ld_state_e;

endpackage

// File: rtl/mips_prog_loader.sv
// Byte-serial framed loader: writes big-endian words to core memory one cycle after each 4th byte.
// Accepts a byte every cycle while loading (never stalls on a write); refuses input in DONE/ERR.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;

    ld_state_e         state_q;
    logic [15:0]       len_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;
    logic [7:0]        xor_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   words_q;
    logic              hold_q;
    logic              start_q;
    logic              done_q;
    logic              error_q;

    logic              acc;
    logic [15:0]       len_d;
    logic              len_bad;
    logic [ADDR_W:0]   words_d;
    logic              last_word;

    always_comb begin
        acc       = in_valid && in_ready;
        len_d     = {len_q[15:8], in_byte};
        len_bad   = (len_d == 16'd0) || ({16'd0, len_d} > 32'(DEPTH));
        words_d   = words_q + (ADDR_W+1)'(1);
        last_word = ({{(31-ADDR_W){1'b0}}, words_d} == {16'd0, len_q});
    end

    assign in_ready = (state_q != DONE) && (state_q != ERR);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= LEN_HI;
            len_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
            hold_q     <= 1'b1;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                LEN_HI: if (acc) begin
                    len_q[15:8] <= in_byte;
                    xor_q       <= xor_q ^ in_byte;
                    state_q     <= LEN_LO;
                end
                LEN_LO: if (acc) begin
                    len_q[7:0] <= in_byte;
                    xor_q      <= xor_q ^ in_byte;
                    if (len_bad) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (acc) begin
                    xor_q      <= xor_q ^ in_byte;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    shift_q    <= {shift_q[15:0], in_byte};
                    // 4th byte completes the word; the write goes out next cycle
                    if (byte_cnt_q == 2'd3) begin
                        we_q    <= 1'b1;
                        wdata_q <= {shift_q, in_byte};
                        addr_q  <= words_q[ADDR_W-1:0];
                        words_q <= words_d;
                        if (last_word) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: if (acc) begin
                    if (in_byte == xor_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end
                end
                DONE, ERR: if (restart) begin
                    state_q    <= LEN_HI;
                    len_q      <= '0;
                    byte_cnt_q <= '0;
                    xor_q      <= '0;
                    addr_q     <= '0;
                    words_q    <= '0;
                    hold_q     <= 1'b1;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                end
                default: state_q <= LEN_HI;
            endcase
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign cpu_start    = start_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frames driven byte by byte, writes logged and compared.
module tb_mips_prog_loader;
    import mips_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        cpu_start;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wr_a[$];
    logic [31:0] wr_d[$];
    int          start_cnt = 0;
    logic [31:0] img[$];

    mips_prog_loader #(.ADDR_W(10)) dut (
        .clk1(clk1), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (!rst) begin
            if (mem_we) begin
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_wdata);
            end
            if (cpu_start) start_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, "_cpu_start"}, 32'(cpu_start), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk1);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 1);
        end else begin
            in_valid = 1'b1;
            in_byte  = b;
            @(posedge clk1);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] n, input bit gaps, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        send_byte(n[15:8]); x ^= n[15:8];
        send_byte(n[7:0]);  x ^= n[7:0];
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = img[i][8*k +: 8];
                if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk1);
                send_byte(b);
                x ^= b;
            end
        end
        send_byte(bad ? (x ^ 8'h03) : x);
    endtask

    task automatic do_restart();
        @(negedge clk1);
        restart = 1'b1;
        @(posedge clk1);
        #1 restart = 1'b0;
    endtask

    initial begin
        int base;
        int sc;
        int mm;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; restart = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk1);
        rst = 1'b0;

        // One-word HLT frame, with an ignored restart mid-frame
        base = wr_a.size(); sc = start_cnt;
        send_byte(8'h00);
        do_restart();
        check("restart_ignored_rdy", 32'(in_ready), 1);
        send_byte(8'h01);
        send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("hlt_we", 32'(mem_we), 1);
        check("hlt_addr", 32'(mem_addr), 0);
        check("hlt_wdata", mem_wdata, 32'hFC000000);
        check("hlt_opcode", 32'(mem_wdata[31:26]), 32'(HLT_OP));
        check("hlt_rdy_during_we", 32'(in_ready), 1);
        send_byte(8'hFD);
        check("hlt_done", 32'(done), 1);
        check("hlt_start", 32'(cpu_start), 1);
        check("hlt_hold", 32'(cpu_hold), 0);
        check("hlt_rdy", 32'(in_ready), 0);
        check("hlt_words", 32'(words_loaded), 1);
        @(posedge clk1); #1;
        check("hlt_start_drop", 32'(cpu_start), 0);
        check("hlt_done_hold", 32'(done), 1);
        check("hlt_nwrites", 32'(wr_a.size() - base), 1);
        check("hlt_nstarts", 32'(start_cnt - sc), 1);

        do_restart();
        check("rs_hold", 32'(cpu_hold), 1);
        check("rs_rdy", 32'(in_ready), 1);
        check("rs_done", 32'(done), 0);
        check("rs_words", 32'(words_loaded), 0);

        // Bad checksum FE
        base = wr_a.size(); sc = start_cnt;
        img = {32'hFC000000};
        send_frame(16'd1, 1'b0, 1'b1);
        check("bad_error", 32'(error), 1);
        check("bad_hold", 32'(cpu_hold), 1);
        check("bad_done", 32'(done), 0);
        repeat (3) @(posedge clk1);
        #1;
        check("bad_nwrites", 32'(wr_a.size() - base), 1);
        check("bad_addr", 32'(wr_a[base]), 0);
        check("bad_nostart", 32'(start_cnt - sc), 0);

        // Zero length, then bytes offered in ERR, then recovery
        do_restart();
        check("err_clr", 32'(error), 0);
        base = wr_a.size();
        send_byte(8'h00); send_byte(8'h00);
        check("len0_error", 32'(error), 1);
        check("len0_rdy", 32'(in_ready), 0);
        @(negedge clk1);
        in_valid = 1'b1; in_byte = 8'h55;
        repeat (3) @(posedge clk1);
        #1 in_valid = 1'b0;
        check("len0_still_err", 32'(error), 1);
        check("len0_nwrites", 32'(wr_a.size() - base), 0);
        do_restart();
        send_frame(16'd1, 1'b0, 1'b0);
        check("recover_done", 32'(done), 1);
        check("recover_wdata", mem_wdata, 32'hFC000000);

        // DEPTH+1 rejected, DEPTH accepted
        do_restart();
        base = wr_a.size();
        send_byte(8'h04); send_byte(8'h01);
        check("len1025_error", 32'(error), 1);
        @(posedge clk1); #1;
        check("len1025_nwrites", 32'(wr_a.size() - base), 0);
        check("len1025_words", 32'(words_loaded), 0);
        do_restart();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back({i[15:0], ~i[15:0]});
        base = wr_a.size();
        send_frame(16'd1024, 1'b0, 1'b0);
        check("full_done", 32'(done), 1);
        check("full_words", 32'(words_loaded), 1024);
        check("full_nwrites", 32'(wr_a.size() - base), 1024);
        mm = 0;
        for (int i = 0; i < 1024 && base + i < wr_a.size(); i++)
            if (wr_a[base+i] !== i[9:0] || wr_d[base+i] !== img[i]) mm++;
        check("full_mismatches", 32'(mm), 0);
        check("full_last_addr", 32'(mem_addr), 1023);

        // Nine-word image with random in_valid gaps
        do_restart();
        img = {32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
               32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        base = wr_a.size();
        send_frame(16'd9, 1'b1, 1'b0);
        check("nine_done", 32'(done), 1);
        check("nine_words", 32'(words_loaded), 9);
        check("nine_nwrites", 32'(wr_a.size() - base), 9);
        for (int i = 0; i < 9; i++) begin
            if (base + i < wr_a.size()) begin
                check($sformatf("nine_addr%0d", i), 32'(wr_a[base+i]), 32'(i));
                check($sformatf("nine_data%0d", i), wr_d[base+i], img[i]);
            end
        end

        // Reset after 6 data bytes of a two-word frame
        do_restart();
        base = wr_a.size();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check("midrst_nwrites", 32'(wr_a.size() - base), 1);
        img = {32'hFC000000};
        base = wr_a.size();
        send_frame(16'd1, 1'b0, 1'b0);
        check("post_done", 32'(done), 1);
        check("post_nwrites", 32'(wr_a.size() - base), 1);
        check("post_addr", 32'(mem_addr), 0);
        check("post_wdata", mem_wdata, 32'hFC000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
